clk_div_sched: RTL and testbench

Run/stop and ratio controller for the divided clock generated from the system clock `CLK`. It replaces a fixed divide-by-4 clock with a programmable half-period. Ratio changes are accepted through a valid/ready handshake and applied only at period boundaries. Stop requests also take effect only at period boundaries, so the divided clock never produces a runt high or low phase, except on reset. Downstream logic uses `CLK_OUT` as a slow clock, or uses `RISE_TICK` as a single-cycle enable at each rising edge.

---
 rtl/clk_div_sched_if.sv | 25 ++
 rtl/clk_div_sched.sv | 122 ++++++++++++
 tb/tb_clk_div_sched.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_sched_if.sv
// clk_div_sched_if: run/config/status bundle for the divided-clock controller.
//   master (driver):  enable, cfg_valid, cfg_half
//   slave  (block):   cfg_ready, cfg_err, clk_out, rise_tick, running
interface clk_div_sched_if #(
  parameter int DIV_W = 4
);
  logic             enable;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             rise_tick;
  logic             running;

  modport master (
    output enable, cfg_valid, cfg_half,
    input  cfg_ready, cfg_err, clk_out, rise_tick, running
  );

  modport slave (
    input  enable, cfg_valid, cfg_half,
    output cfg_ready, cfg_err, clk_out, rise_tick, running
  );
endinterface

// File: rtl/clk_div_sched.sv
// clk_div_sched: run/stop and ratio controller for a divided clock.
//   clk_i     system clock, all logic on the rising edge
//   rst_i     synchronous active-high reset
//   bus       clk_div_sched_if.slave:
//               enable     level request to run clk_out
//               cfg_valid/cfg_half/cfg_ready  half-period handshake
//               cfg_err    one-cycle pulse after an accepted zero half-period
//               clk_out    registered divided clock (period = 2*half)
//               rise_tick  one-cycle pulse in the cycle after clk_out rises
//               running    high while in RUN
// Ratio changes and stops land only on the falling edge of clk_out (the
// period boundary), so no runt phase appears except on reset.
module clk_div_sched #(
  parameter int DIV_W        = 4,
  parameter int DEFAULT_HALF = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  clk_div_sched_if.slave bus
);

  typedef enum logic {STOPPED = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_half_q, cur_half_d;
  logic [DIV_W-1:0] new_half_q, new_half_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  logic accept, zero, last;

  assign accept = bus.cfg_valid & ready_q;
  assign zero   = (bus.cfg_half == '0);
  // cur_half is never 0, so the subtraction cannot wrap
  assign last   = (cnt_q == cur_half_q - DIV_W'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_half_d = cur_half_q;
    new_half_d = new_half_q;
    pend_d     = pend_q;
    clk_out_d  = clk_out_q;
    rise_d     = 1'b0;
    err_d      = accept & zero;
    case (state_q)
      STOPPED: begin
        clk_out_d = 1'b0;
        cnt_d     = '0;
        // A shadow captured on the stopping boundary is applied here; no
        // phase is in flight, so nothing can be truncated.
        if (pend_q) begin
          cur_half_d = new_half_q;
          pend_d     = 1'b0;
        end
        if (accept && !zero) cur_half_d = bus.cfg_half;
        if (bus.enable) state_d = RUN;
      end
      RUN: begin
        if (last) begin
          cnt_d     = '0;
          clk_out_d = ~clk_out_q;
          if (!clk_out_q) begin
            rise_d = 1'b1;
          end else begin
            // falling edge = period boundary
            if (pend_q) begin
              cur_half_d = new_half_q;
              pend_d     = 1'b0;
            end
            if (!bus.enable) state_d = STOPPED;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
        // Accept after the boundary update so a transfer on the boundary
        // edge lands in the shadow for the following period.
        if (accept && !zero) begin
          new_half_d = bus.cfg_half;
          pend_d     = 1'b1;
        end
      end
      default: state_d = STOPPED;
    endcase
    ready_d = ~pend_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= STOPPED;
      cnt_q      <= '0;
      cur_half_q <= DIV_W'(DEFAULT_HALF);
      new_half_q <= '0;
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      rise_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_half_q <= cur_half_d;
      new_half_q <= new_half_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      rise_q     <= rise_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.clk_out   = clk_out_q;
  assign bus.rise_tick = rise_q;
  assign bus.running   = (state_q == RUN);
  assign bus.cfg_ready = ready_q;
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_clk_div_sched.sv
module tb_clk_div_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clk_div_sched_if #(.DIV_W(4)) bus ();

  clk_div_sched #(.DIV_W(4), .DEFAULT_HALF(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase level plus cycles left in the current phase.
  bit m_run, m_lvl, m_pend, m_rise, m_err;
  int m_half, m_new, m_left;

  logic [4:0] act;
  assign act = {bus.clk_out, bus.rise_tick, bus.running, bus.cfg_ready, bus.cfg_err};

  function automatic logic [4:0] expv();
    return {m_lvl, m_rise, m_run, ~m_pend, m_err};
  endfunction

  task automatic model_edge(input bit r, input bit en, input bit v, input int h);
    bit acc;
    acc    = v && !m_pend;
    m_rise = 1'b0;
    m_err  = acc && (h == 0);
    if (r) begin
      m_run = 0; m_lvl = 0; m_pend = 0; m_err = 0; m_half = 2; m_left = 0;
      return;
    end
    if (!m_run) begin
      if (m_pend) begin m_half = m_new; m_pend = 0; end
      if (acc && h != 0) m_half = h;
      if (en) begin m_run = 1; m_lvl = 0; m_left = m_half; end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (!m_lvl) begin
          m_lvl = 1; m_rise = 1; m_left = m_half;
        end else begin
          m_lvl = 0;
          if (m_pend) begin m_half = m_new; m_pend = 0; end
          m_left = m_half;
          if (!en) m_run = 0;
        end
      end
      if (acc && h != 0) begin m_new = h; m_pend = 1; end
    end
  endtask

  task automatic step(input bit r, input bit en, input bit v, input int h);
    rst           = r;
    bus.enable    = en;
    bus.cfg_valid = v;
    bus.cfg_half  = 4'(h);
    @(posedge clk);
    model_edge(r, en, v, h);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    checks++;
    if (act !== 5'b00010) begin
      errors++; $display("FAIL reset_state act=%b exp=%b", act, 5'b00010);
    end
  endtask

  task automatic test_default_run();
    step(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0);
      checks++;
      if (bus.clk_out !== ((i % 4) >= 2) || bus.rise_tick !== ((i % 4) == 2)) begin
        errors++;
        $display("FAIL default_pattern i=%0d clk=%b rise=%b exp_clk=%b", i, bus.clk_out, bus.rise_tick, (i % 4) >= 2);
      end
      checks++;
      if (act !== expv()) begin errors++; $display("FAIL default_model act=%b exp=%b", act, expv()); end
    end
  endtask

  task automatic test_reconfig();
    int lo, hi;
    bit ok;
    ok = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.clk_out) begin ok = 1; break; end
      step(0, 1, 0, 0);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL reconfig_find_high timeout"); end
    step(0, 1, 1, 5);
    checks++;
    if (bus.cfg_ready !== 1'b0 || act !== expv()) begin
      errors++; $display("FAIL reconfig_ready_low act=%b exp=%b", act, expv());
    end
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 0, 0);
      checks++;
      if (act !== expv()) begin errors++; $display("FAIL reconfig_model act=%b exp=%b", act, expv()); end
      if (bus.cfg_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok || bus.clk_out !== 1'b0) begin
      errors++; $display("FAIL reconfig_ready_return ready=%b clk=%b exp 1/0", bus.cfg_ready, bus.clk_out);
    end
    lo = 1;
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 0, 0);
      checks++;
      if (act !== expv()) begin errors++; $display("FAIL reconfig_model act=%b exp=%b", act, expv()); end
      if (bus.clk_out) break;
      lo++;
    end
    hi = 1;
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 0, 0);
      if (!bus.clk_out) break;
      hi++;
    end
    checks++;
    if (lo != 5 || hi != 5) begin
      errors++; $display("FAIL reconfig_period lo=%0d hi=%0d exp 5/5", lo, hi);
    end
  endtask

  task automatic test_stop();
    int hi;
    bit ok;
    step(1, 0, 0, 0);
    step(0, 1, 1, 3);
    hi = 0; ok = 0;
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, 0);
      checks++;
      if (act !== expv()) begin errors++; $display("FAIL stop_model act=%b exp=%b", act, expv()); end
      if (bus.clk_out) hi++;
      if (!bus.running) begin ok = 1; break; end
    end
    checks++;
    if (!ok || hi != 3 || bus.clk_out !== 1'b0) begin
      errors++; $display("FAIL stop_latency stopped=%0d hi=%0d clk=%b exp 1/3/0", ok, hi, bus.clk_out);
    end
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0);
      checks++;
      if (bus.clk_out !== 1'b0 || bus.running !== 1'b0) begin
        errors++; $display("FAIL stop_hold clk=%b run=%b exp 0/0", bus.clk_out, bus.running);
      end
    end
  endtask

  task automatic test_illegal();
    int last_rise;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    checks++;
    if (bus.cfg_err !== 1'b1 || bus.cfg_ready !== 1'b1) begin
      errors++; $display("FAIL illegal_err err=%b ready=%b exp 1/1", bus.cfg_err, bus.cfg_ready);
    end
    step(0, 1, 0, 0);
    checks++;
    if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL illegal_err_width err=%b exp 0", bus.cfg_err); end
    last_rise = -1;
    for (int k = 0; k < 14; k++) begin
      step(0, 1, 0, 0);
      checks++;
      if (act !== expv()) begin errors++; $display("FAIL illegal_model act=%b exp=%b", act, expv()); end
      if (bus.rise_tick) begin
        if (last_rise >= 0) begin
          checks++;
          if (k - last_rise != 4) begin
            errors++; $display("FAIL illegal_period got=%0d exp=4", k - last_rise);
          end
        end
        last_rise = k;
      end
    end
  endtask

  task automatic test_cfg_enable();
    step(1, 0, 0, 0);
    step(0, 1, 1, 1);
    checks++;
    if (bus.clk_out !== 1'b0 || bus.running !== 1'b1) begin
      errors++; $display("FAIL cfg_en_start clk=%b run=%b exp 0/1", bus.clk_out, bus.running);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      checks++;
      if (bus.clk_out !== (i % 2 == 0) || bus.rise_tick !== (i % 2 == 0) || act !== expv()) begin
        errors++; $display("FAIL cfg_en_toggle i=%0d act=%b exp=%b", i, act, expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    int last_rise;
    bit ok;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 7);
    ok = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.clk_out) begin ok = 1; break; end
      step(0, 1, 0, 0);
    end
    checks++;
    if (!ok || bus.cfg_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_setup high=%0d ready=%b exp 1/0", ok, bus.cfg_ready);
    end
    step(1, 1, 0, 0);
    checks++;
    if (act !== 5'b00010) begin errors++; $display("FAIL rst_mid_state act=%b exp=%b", act, 5'b00010); end
    last_rise = -1;
    for (int k = 0; k < 14; k++) begin
      step(0, 1, 0, 0);
      checks++;
      if (act !== expv()) begin errors++; $display("FAIL rst_mid_model act=%b exp=%b", act, expv()); end
      if (bus.rise_tick) begin
        if (last_rise >= 0) begin
          checks++;
          if (k - last_rise != 4) begin
            errors++; $display("FAIL rst_mid_period got=%0d exp=4", k - last_rise);
          end
        end
        last_rise = k;
      end
    end
  endtask

  task automatic test_random();
    bit en;
    en = 1;
    step(1, 0, 0, 0);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      step($urandom_range(0, 127) == 0, en, $urandom_range(0, 3) == 0, $urandom_range(0, 15));
      checks++;
      if (act !== expv()) begin
        errors++; $display("FAIL random_model cyc=%0d act=%b exp=%b", k, act, expv());
      end
    end
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_half  = '0;
    test_reset();
    test_default_run();
    test_reconfig();
    test_stop();
    test_illegal();
    test_cfg_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
